// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the ALU command sequencer: opcode constants,
// FSM state encoding, flag bit positions and the opcode legality check.
package alu_seq_pkg;

    localparam int DW  = 16;  // operand / result width
    localparam int OPW = 4;   // opcode width
    localparam int FW  = 3;   // flag vector width

    // Flag bit positions within out_flags
    localparam int FLAG_ERR  = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [OPW-1:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_SRA = 4'b0010,
        OP_ROL = 4'b0011,
        OP_AND = 4'b1000,
        OP_OR  = 4'b1001,
        OP_XOR = 4'b1010,
        OP_NOT = 4'b1011,
        OP_SLL = 4'b1100,
        OP_SRL = 4'b1101
    } opcode_e;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        ISSUE   = 3'd3,
        WAIT    = 3'd4,
        DONE    = 3'd5
    } state_e;

    // True for the ten opcodes the ALU core implements
    function automatic logic op_legal(input logic [OPW-1:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_SRA, OP_ROL,
            OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_SLL, OP_SRL: ok = 1'b1;
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Flags for a result the core actually produced (err is never set here)
    function automatic logic [FW-1:0] result_flags(input logic [DW-1:0] r);
        logic [FW-1:0] f;
        f            = '0;
        f[FLAG_ZERO] = (r == '0);
        f[FLAG_NEG]  = r[DW-1];
        f[FLAG_ERR]  = 1'b0;
        return f;
    endfunction

    // Flags reported for a rejected opcode: error, with a zero result
    function automatic logic [FW-1:0] illegal_flags();
        logic [FW-1:0] f;
        f            = '0;
        f[FLAG_ERR]  = 1'b1;
        f[FLAG_ZERO] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Bus bundle between the sequencer, its command source, the external ALU
// core and the result consumer. The slave side is the sequencer itself.
interface alu_seq_if;
    import alu_seq_pkg::*;

    // command beats in
    logic [DW-1:0]  in_data;
    logic           in_valid;
    logic           in_ready;
    // ALU core side
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_result;
    // result out
    logic [DW-1:0]  out_result;
    logic [FW-1:0]  out_flags;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  op_count;

    modport slave (
        input  in_data, in_valid, alu_result, out_ready,
        output in_ready, alu_a, alu_b, alu_op,
               out_result, out_flags, out_valid, op_count
    );

    modport master (
        output in_data, in_valid, alu_result, out_ready,
        input  in_ready, alu_a, alu_b, alu_op,
               out_result, out_flags, out_valid, op_count
    );

endinterface

// File: rtl/alu_seq.sv
// Command sequencer: collects A, B and opcode beats, presents them to an
// external registered ALU core, captures the result with flags and holds it
// until the consumer takes it. Counts accepted results.
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    state_e         state_q, state_d;
    logic [DW-1:0]  a_q, b_q, res_q, cnt_q;
    logic [OPW-1:0] op_q;
    logic [FW-1:0]  flags_q;
    logic           in_rdy, out_vld;
    logic           in_fire, out_fire;
    logic           op_ok;

    assign in_fire  = bus.in_valid && in_rdy;
    assign out_fire = out_vld && bus.out_ready;
    assign op_ok    = op_legal(bus.in_data[OPW-1:0]);

    // State register; reset drops any partial command or pending result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD_A;
        else     state_q <= state_d;
    end

    // Next-state: three load beats, then a fixed two-cycle ALU round trip
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_A:  if (in_fire) state_d = LOAD_B;
            LOAD_B:  if (in_fire) state_d = LOAD_OP;
            LOAD_OP: if (in_fire) state_d = op_ok ? ISSUE : DONE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = DONE;
            DONE:    if (out_fire) state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
    end

    // Handshake outputs decoded purely from state
    always_comb begin
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state_q)
            LOAD_A, LOAD_B, LOAD_OP: in_rdy  = 1'b1;
            DONE:                    out_vld = 1'b1;
            default: ;
        endcase
    end

    // Operand / opcode registers feed the ALU core and stay put until reloaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else if (in_fire) begin
            case (state_q)
                LOAD_A:  a_q  <= bus.in_data;
                LOAD_B:  b_q  <= bus.in_data;
                LOAD_OP: op_q <= bus.in_data[OPW-1:0];
                default: ;
            endcase
        end
    end

    // Result capture: core output at end of WAIT, or error result on an illegal opcode beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            flags_q <= '0;
        end else if (state_q == WAIT) begin
            res_q   <= bus.alu_result;
            flags_q <= result_flags(bus.alu_result);
        end else if (state_q == LOAD_OP && in_fire && !op_ok) begin
            res_q   <= '0;
            flags_q <= illegal_flags();
        end
    end

    // Completed-result counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cnt_q <= '0;
        else if (out_fire) cnt_q <= cnt_q + 1'b1;
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = out_vld;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.out_result = res_q;
    assign bus.out_flags  = flags_q;
    assign bus.op_count   = cnt_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq with a registered ALU core model attached
// and a transaction-level reference for results, flags, latency and count.
module tb_alu_seq;

    logic clk;
    logic rst;
    alu_seq_if bus ();

    alu_seq dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_cnt;
    logic [15:0] legal_mask = 16'h3F0F;  // bit k set => opcode k implemented

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: what the core computes for a given command
    function automatic logic [15:0] core(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] op);
        int s;
        s = int'(b[3:0]);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return 16'($signed(a) >>> s);
            4'd3:    return (s == 0) ? a : 16'((a << s) | (a >> (16 - s)));
            4'd8:    return a & b;
            4'd9:    return a | b;
            4'd10:   return a ^ b;
            4'd11:   return ~a;
            4'd12:   return a << s;
            4'd13:   return a >> s;
            default: return 16'h0000;
        endcase
    endfunction

    // External core with one cycle of latency
    always @(posedge clk) bus.alu_result <= core(bus.alu_a, bus.alu_b, bus.alu_op);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        chk("beat_rdy", {31'd0, bus.in_ready}, 32'd1);
        tick();
    endtask

    // One full command: beats, latency, hold phase, accept and count
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input int hold);
        logic [15:0] er, hi;
        logic [2:0]  ef;
        bit          lg;
        lg = legal_mask[op];
        er = lg ? core(a, b, op) : 16'h0000;
        ef = lg ? {1'b0, er[15], er == 16'h0000} : 3'b101;
        hi = 16'($urandom);
        send_beat(a);
        send_beat(b);
        send_beat({hi[15:4], op});
        if (lg) begin
            chk("iss_vld", {31'd0, bus.out_valid}, 32'd0);
            chk("iss_a", {16'd0, bus.alu_a}, {16'd0, a});
            chk("iss_b", {16'd0, bus.alu_b}, {16'd0, b});
            chk("iss_op", {28'd0, bus.alu_op}, {28'd0, op});
            chk("iss_rdy", {31'd0, bus.in_ready}, 32'd0);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 16'($urandom);
            tick();
            chk("wait_vld", {31'd0, bus.out_valid}, 32'd0);
            chk("wait_a", {16'd0, bus.alu_a}, {16'd0, a});
            chk("wait_b", {16'd0, bus.alu_b}, {16'd0, b});
            chk("wait_op", {28'd0, bus.alu_op}, {28'd0, op});
            tick();
        end
        bus.out_ready = 1'b0;
        chk("done_vld", {31'd0, bus.out_valid}, 32'd1);
        chk("done_res", {16'd0, bus.out_result}, {16'd0, er});
        chk("done_flg", {29'd0, bus.out_flags}, {29'd0, ef});
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'($urandom);
            tick();
            chk("hold_vld", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_res", {16'd0, bus.out_result}, {16'd0, er});
            chk("hold_flg", {29'd0, bus.out_flags}, {29'd0, ef});
            chk("hold_rdy", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("acc_vld", {31'd0, bus.out_valid}, 32'd0);
        chk("acc_rdy", {31'd0, bus.in_ready}, 32'd1);
        chk("acc_cnt", {16'd0, bus.op_count}, {16'd0, exp_cnt});
        bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [3:0]  rop;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        bus.out_ready = 1'b0;
        exp_cnt      = 16'h0000;
        tick();
        tick();
        chk("rst_rdy", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_vld", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_a", {16'd0, bus.alu_a}, 32'd0);
        chk("rst_b", {16'd0, bus.alu_b}, 32'd0);
        chk("rst_op", {28'd0, bus.alu_op}, 32'd0);
        chk("rst_res", {16'd0, bus.out_result}, 32'd0);
        chk("rst_flg", {29'd0, bus.out_flags}, 32'd0);
        chk("rst_cnt", {16'd0, bus.op_count}, 32'd0);
        rst = 1'b0;
        tick();

        // directed: ADD, SUB to zero, SUB to negative, illegal, long hold
        do_op(16'h0005, 16'h0003, 4'h0, 0);
        chk("add_res", {16'd0, bus.out_result}, 32'h0008);
        do_op(16'h0003, 16'h0003, 4'h1, 1);
        do_op(16'h0000, 16'h0001, 4'h1, 0);
        chk("sub_neg", {16'd0, bus.out_result}, 32'hFFFF);
        do_op(16'h1234, 16'h5678, 4'h7, 0);
        do_op(16'h00F0, 16'h0F0F, 4'h9, 5);

        // reset while waiting on the core
        send_beat(16'h0009);
        send_beat(16'h0004);
        send_beat(16'h0000);
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_vld", {31'd0, bus.out_valid}, 32'd0);
        chk("mrst_rdy", {31'd0, bus.in_ready}, 32'd1);
        chk("mrst_cnt", {16'd0, bus.op_count}, 32'd0);
        chk("mrst_a", {16'd0, bus.alu_a}, 32'd0);
        exp_cnt = 16'h0000;
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_vld2", {31'd0, bus.out_valid}, 32'd0);
        do_op(16'h0002, 16'h0001, 4'hC, 0);
        chk("sll_res", {16'd0, bus.out_result}, 32'h0004);

        // reset after only operand A: next three beats start a fresh command
        send_beat(16'hAAAA);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_cnt = 16'h0000;
        do_op(16'h0007, 16'h0002, 4'hD, 0);

        // randomized commands over the full opcode space
        for (int i = 0; i < 60; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rop = 4'($urandom);
            do_op(ra, rb, rop, int'($urandom_range(0, 3)));
        end

        // counter wrap from 0xFFFF
        bus.out_ready = 1'b0;
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        exp_cnt = 16'hFFFF;
        do_op(16'h0001, 16'h0001, 4'h0, 0);
        chk("wrap_cnt", {16'd0, bus.op_count}, 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
